// File: rtl/issue_queue.sv
// In-order dispatch buffer between the decoder and the reservation stations.
// Circular FIFO whose head is offered to the RS and retried until accepted.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int REG_W  = 6,
  parameter int WORD_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_unit,
  input  logic [REG_W-1:0]           in_reg1,
  input  logic [REG_W-1:0]           in_reg2,
  input  logic [REG_W-1:0]           in_reg3,
  input  logic                       in_hasimm,
  input  logic [WORD_W-1:0]          in_imm,
  output logic [2:0]                 unit,
  output logic [REG_W-1:0]           reg1,
  output logic [REG_W-1:0]           reg2,
  output logic [REG_W-1:0]           reg3,
  output logic                       hasimm,
  output logic [WORD_W-1:0]          imm,
  output logic                       enable,
  input  logic                       accept,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                stall_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, HALTED} state_e;

  typedef struct packed {
    logic [2:0]        unit;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  reg3;
    logic              hasimm;
    logic [WORD_W-1:0] imm;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   stall_q, stall_d;
  state_e        state_q, state_d;
  logic          running, nonEmpty, headOp, headHalt, headIllegal;
  logic          push, pop;

  assign head = mem_q[rd_ptr_q];

  // Codes 110/111 are never offered; a halt is offered once and pops regardless of accept.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    stall_d     = stall_q;
    state_d     = state_q;
    running     = (state_q == RUN);
    nonEmpty    = running && (count_q != '0);
    headOp      = (head.unit <= 3'd4);
    headHalt    = (head.unit == 3'd5);
    headIllegal = (head.unit[2:1] == 2'b11);
    in_ready    = running && (count_q < CW'(DEPTH));
    enable      = nonEmpty && (headOp || headHalt);
    push        = in_valid && in_ready;
    pop         = nonEmpty && ((headOp && accept) || headHalt || headIllegal);

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (enable && !accept && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;

    if (nonEmpty && headHalt) begin
      state_d = HALTED;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
      state_q  <= RUN;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm};
  end

  assign unit         = head.unit;
  assign reg1         = head.reg1;
  assign reg2         = head.reg2;
  assign reg3         = head.reg3;
  assign hasimm       = head.hasimm;
  assign imm          = head.imm;
  assign halted       = (state_q == HALTED);
  assign count        = count_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_issue_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_unit = '0;
  logic [5:0]  in_reg1 = '0, in_reg2 = '0, in_reg3 = '0;
  logic        in_hasimm = 1'b0;
  logic [31:0] in_imm = '0;
  logic [2:0]  unit;
  logic [5:0]  reg1, reg2, reg3;
  logic        hasimm;
  logic [31:0] imm;
  logic        enable;
  logic        accept = 1'b0;
  logic        halted;
  logic [3:0]  count;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  issue_queue #(.DEPTH(8), .REG_W(6), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_unit(in_unit), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_reg3(in_reg3),
    .in_hasimm(in_hasimm), .in_imm(in_imm), .unit(unit), .reg1(reg1), .reg2(reg2),
    .reg3(reg3), .hasimm(hasimm), .imm(imm), .enable(enable), .accept(accept),
    .halted(halted), .count(count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending instructions plus halt flag and stall tally.
  typedef struct {
    logic [2:0]  u;
    logic [5:0]  r1, r2, r3;
    logic        hi;
    logic [31:0] im;
  } ent_t;

  ent_t mq[$];
  bit   mHalted = 1'b0;
  int   mStall = 0;
  bit   mReady;
  ent_t newEnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mHalted = 1'b0;
      mStall  = 0;
    end else begin
      mReady = !mHalted && (mq.size() < 8);
      if (!mHalted && mq.size() > 0) begin
        if (mq[0].u <= 3'd4) begin
          if (accept) void'(mq.pop_front());
          else if (mStall < 65535) mStall++;
        end else if (mq[0].u == 3'd5) begin
          if (!accept && mStall < 65535) mStall++;
          void'(mq.pop_front());
          mHalted = 1'b1;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (in_valid && mReady) begin
        newEnt = '{in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm};
        mq.push_back(newEnt);
      end
      if (mHalted) mq.delete();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit expEnable;
    expEnable = !mHalted && (mq.size() > 0) && (mq[0].u <= 3'd5);
    check("in_ready", 32'(in_ready), 32'(!mHalted && mq.size() < 8));
    check("enable", 32'(enable), 32'(expEnable));
    check("count", 32'(count), 32'(mq.size()));
    check("halted", 32'(halted), 32'(mHalted));
    check("stall_cycles", 32'(stall_cycles), 32'(mStall));
    if (expEnable) begin
      check("unit", 32'(unit), 32'(mq[0].u));
      check("reg1", 32'(reg1), 32'(mq[0].r1));
      check("reg2", 32'(reg2), 32'(mq[0].r2));
      if (!mq[0].hi) check("reg3", 32'(reg3), 32'(mq[0].r3));
      check("hasimm", 32'(hasimm), 32'(mq[0].hi));
      check("imm", imm, mq[0].im);
    end
  endtask

  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input logic v, input logic [2:0] u, input logic [5:0] r1,
                               input logic [5:0] r2, input logic [5:0] r3, input logic hi,
                               input logic [31:0] im, input logic acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_unit   = u;
    in_reg1   = r1;
    in_reg2   = r2;
    in_reg3   = r3;
    in_hasimm = hi;
    in_imm    = im;
    accept    = acc;
  endtask

  task automatic idle(input logic acc);
    applyStimulus(1'b0, 3'd0, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0, acc);
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int accPct;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and single add r3,r1,r2.
    sampleNow();
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    applyStimulus(1'b1, 3'd2, 6'd3, 6'd1, 6'd2, 1'b0, 32'd0, 1'b1);
    sampleNow();
    check("t1_enable_before", 32'(enable), 32'd0);
    idle(1'b1);
    sampleNow();
    check("t1_enable", 32'(enable), 32'd1);
    check("t1_reg1", 32'(reg1), 32'd3);
    check("t1_reg2", 32'(reg2), 32'd1);
    check("t1_reg3", 32'(reg3), 32'd2);
    idle(1'b1);
    sampleNow();
    check("t1_count_after", 32'(count), 32'd0);
    check("t1_enable_after", 32'(enable), 32'd0);

    // Fill with accept low: stalls accrue from the 2nd push cycle (7), then 5 more holds.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'd2, 6'(10 + i), 6'd1, 6'd2, 1'b0, 32'd0, 1'b0);
    idle(1'b0);
    sampleNow();
    check("t2_count_full", 32'(count), 32'd8);
    check("t2_ready_full", 32'(in_ready), 32'd0);
    check("t2_stall_fill", 32'(stall_cycles), 32'd7);
    repeat (5) idle(1'b0);
    sampleNow();
    check("t2_stall_hold", 32'(stall_cycles), 32'd12);
    check("t2_head_stable", 32'(reg1), 32'd10);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      sampleNow();
      check("t2_drain_order", 32'(reg1), 32'(10 + i));
    end
    idle(1'b1);
    sampleNow();
    check("t2_count_empty", 32'(count), 32'd0);

    // Pointer wrap with one entry in flight.
    doReset();
    applyStimulus(1'b1, 3'd0, 6'd0, 6'd5, 6'd0, 1'b0, 32'd0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 3'd0, 6'(i), 6'd5, 6'd0, 1'b0, 32'd0, 1'b1);
      sampleNow();
      check("t3_count", 32'(count), 32'd1);
      check("t3_order", 32'(reg1), 32'(i - 1));
    end

    // mv r4,#-7 then halt then add.
    doReset();
    applyStimulus(1'b1, 3'd4, 6'd4, 6'd0, 6'd0, 1'b1, 32'hFFFF_FFF9, 1'b1);
    applyStimulus(1'b1, 3'd5, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0, 1'b1);
    sampleNow();
    check("t4_mv_unit", 32'(unit), 32'd4);
    check("t4_mv_imm", imm, 32'hFFFF_FFF9);
    applyStimulus(1'b1, 3'd2, 6'd7, 6'd8, 6'd9, 1'b0, 32'd0, 1'b1);
    sampleNow();
    check("t4_halt_enable", 32'(enable), 32'd1);
    check("t4_halt_unit", 32'(unit), 32'd5);
    idle(1'b1);
    sampleNow();
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_count", 32'(count), 32'd0);
    check("t4_ready", 32'(in_ready), 32'd0);
    check("t4_enable", 32'(enable), 32'd0);
    repeat (3) idle(1'b1);

    // Illegal code is dropped without being offered.
    doReset();
    applyStimulus(1'b1, 3'd6, 6'd1, 6'd1, 6'd1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 3'd1, 6'd12, 6'd13, 6'd0, 1'b1, 32'd16, 1'b1);
    sampleNow();
    check("t5_illegal_enable", 32'(enable), 32'd0);
    idle(1'b1);
    sampleNow();
    check("t5_sw_enable", 32'(enable), 32'd1);
    check("t5_sw_unit", 32'(unit), 32'd1);
    check("t5_sw_reg1", 32'(reg1), 32'd12);

    // Asynchronous reset in the middle of a stall.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 3'd3, 6'(20 + i), 6'd1, 6'd2, 1'b0, 32'd0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_enable_async", 32'(enable), 32'd0);
    check("t6_count_async", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_halted", 32'(halted), 32'd0);

    // Randomized traffic with varying back-pressure.
    accPct = 75;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] u;
      int r;
      if (c % 100 == 0) accPct = $urandom_range(10, 100);
      r = $urandom_range(0, 99);
      if (r < 90)      u = 3'($urandom_range(0, 4));
      else if (r < 96) u = 3'($urandom_range(6, 7));
      else             u = 3'd5;
      if (mHalted && $urandom_range(0, 3) == 0) doReset();
      else if ($urandom_range(0, 299) == 0) doReset();
      else applyStimulus(1'($urandom_range(0, 3) != 0), u, 6'($urandom), 6'($urandom),
                         6'($urandom), 1'($urandom), $urandom,
                         1'($urandom_range(1, 100) <= accPct));
    end

    idle(1'b0);
    sampleNow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
